// File: rtl/addr_gen_pkg.sv
// Shared types for the addr_gen phase/address generator.
package addr_gen_pkg;
  typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_PING, MODE_HOLD} mode_t;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/addr_gen_step.sv
// Combinational next-state unit for the addr_gen base counter (enabled advance only).
module addr_gen_step
  import addr_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             dir,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] incr,
  output logic [WIDTH-1:0] cnt_n,
  output logic             dir_n,
  output logic             wrap_n
);
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH:0] sum;
  assign sum = {1'b0, cnt} + {1'b0, incr};

  always_comb begin
    cnt_n  = cnt;
    dir_n  = dir;
    wrap_n = 1'b0;
    case (mode)
      MODE_UP: begin
        cnt_n  = sum[WIDTH-1:0];
        dir_n  = DIR_UP;
        wrap_n = sum[WIDTH];
      end
      MODE_DOWN: begin
        cnt_n  = cnt - incr;
        dir_n  = DIR_DOWN;
        wrap_n = (cnt < incr);
      end
      MODE_PING: begin
        // Turn-around clamps to the rail, so a zero step still turns at the boundary
        if (dir == DIR_UP) begin
          if (sum >= MAX_EXT) begin
            cnt_n  = {WIDTH{1'b1}};
            dir_n  = DIR_DOWN;
            wrap_n = 1'b1;
          end else begin
            cnt_n = sum[WIDTH-1:0];
          end
        end else begin
          if (cnt <= incr) begin
            cnt_n  = '0;
            dir_n  = DIR_UP;
            wrap_n = 1'b1;
          end else begin
            cnt_n = cnt - incr;
          end
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/addr_gen.sv
// Base phase counter with step/mode/load driving NCH offset ROM addresses.
// Optional re-phase input enabled by defining ADDR_GEN_SYNC_EN.
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef ADDR_GEN_SYNC_EN
  input  logic                 sync,
`endif
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     incr,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic [NCH*WIDTH-1:0] offset,
  output logic [NCH*WIDTH-1:0] addr,
  output logic                 dir,
  output logic                 wrap
);
  mode_t            mode_e;
  logic [WIDTH-1:0] cnt, cnt_n, step_cnt;
  logic             dir_n, wrap_n, step_dir, step_wrap, upd;

  assign mode_e = mode_t'(mode);

  addr_gen_step #(.WIDTH(WIDTH)) u_step (
    .cnt    (cnt),
    .dir    (dir),
    .mode   (mode_e),
    .incr   (incr),
    .cnt_n  (step_cnt),
    .dir_n  (step_dir),
    .wrap_n (step_wrap)
  );

  always_comb begin
    cnt_n  = cnt;
    dir_n  = dir;
    wrap_n = 1'b0;
    upd    = 1'b0;
`ifdef ADDR_GEN_SYNC_EN
    if (sync) begin
      cnt_n = '0;
      dir_n = DIR_UP;
      upd   = 1'b1;
    end else
`endif
    if (load) begin
      cnt_n = load_val;
      upd   = 1'b1;
      if (mode_e == MODE_UP)        dir_n = DIR_UP;
      else if (mode_e == MODE_DOWN) dir_n = DIR_DOWN;
    end else if (en && mode_e != MODE_HOLD) begin
      cnt_n  = step_cnt;
      dir_n  = step_dir;
      wrap_n = step_wrap;
      upd    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dir  <= DIR_UP;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      dir  <= dir_n;
      wrap <= wrap_n;
    end
  end

  // Offsets are sampled only on state updates, so addr stays frozen while holding
  logic [WIDTH-1:0] addr_q [NCH];
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    always_ff @(posedge clk) begin
      if (rst)      addr_q[k] <= '0;
      else if (upd) addr_q[k] <= cnt_n + offset[k*WIDTH +: WIDTH];
    end
    assign addr[k*WIDTH +: WIDTH] = addr_q[k];
  end
endmodule

// File: tb/tb_addr_gen.sv
// Self-checking bench for addr_gen (WIDTH=8, NCH=2); re-phase tests when ADDR_GEN_SYNC_EN is defined.
module tb_addr_gen;
  localparam int W = 8;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst, en, load, sync;
  logic [1:0]     mode;
  logic [W-1:0]   incr, load_val;
  logic [N*W-1:0] offset, addr;
  logic           dir, wrap;

  int tests = 0;
  int fails = 0;

  // reference state
  int m_cnt, m_dir, m_wrap;
  int m_addr [N];

  addr_gen #(.WIDTH(W), .NCH(N)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ADDR_GEN_SYNC_EN
    .sync     (sync),
`endif
    .en       (en),
    .mode     (mode),
    .incr     (incr),
    .load     (load),
    .load_val (load_val),
    .offset   (offset),
    .addr     (addr),
    .dir      (dir),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic int off_of(int k);
    return int'(offset[k*W +: W]);
  endfunction

  // Reference: plain integer arithmetic applied from the rules, one edge at a time
  task automatic model_edge();
    int c, i, s;
    bit upd;
    bit sync_on;
    c = m_cnt; upd = 0;
    i = int'(incr);
    sync_on = 0;
`ifdef ADDR_GEN_SYNC_EN
    sync_on = sync;
`endif
    if (rst) begin
      m_cnt = 0; m_dir = 0; m_wrap = 0;
      for (int k = 0; k < N; k++) m_addr[k] = 0;
      return;
    end
    m_wrap = 0;
    if (sync_on) begin
      m_cnt = 0; m_dir = 0; upd = 1;
    end else if (load) begin
      m_cnt = int'(load_val); upd = 1;
      if (mode == 2'd0) m_dir = 0;
      if (mode == 2'd1) m_dir = 1;
    end else if (en && mode != 2'd3) begin
      upd = 1;
      if (mode == 2'd0) begin
        s = c + i; m_wrap = (s > 255) ? 1 : 0; m_cnt = s % 256; m_dir = 0;
      end else if (mode == 2'd1) begin
        m_wrap = (c < i) ? 1 : 0; m_cnt = (c - i + 256) % 256; m_dir = 1;
      end else if (m_dir == 0) begin
        if (c + i >= 255) begin m_cnt = 255; m_dir = 1; m_wrap = 1; end
        else m_cnt = c + i;
      end else begin
        if (c <= i) begin m_cnt = 0; m_dir = 0; m_wrap = 1; end
        else m_cnt = c - i;
      end
    end
    if (upd)
      for (int k = 0; k < N; k++) m_addr[k] = (m_cnt + off_of(k)) % 256;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; en = 0; load = 0; sync = 0; mode = 2'd0;
    incr = '0; load_val = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    offset = {8'd64, 8'd0}; mode = 2'd0; incr = 8'd1; en = 1; rst = 1;
    repeat (2) begin
      tick();
      tests++;
      if (addr !== 16'h0 || dir !== 1'b0 || wrap !== 1'b0) begin
        fails++;
        $display("FAIL reset: addr=%h dir=%b wrap=%b, required addr=0000 dir=0 wrap=0", addr, dir, wrap);
      end
    end
    rst = 0;
    tick();
    tests++;
    if (addr[7:0] !== 8'd1 || addr[15:8] !== 8'd65) begin
      fails++;
      $display("FAIL reset_release: addr0=%0d addr1=%0d, required 1 65", addr[7:0], addr[15:8]);
    end
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_c [2];
    logic [7:0] exp_a1 [2];
    logic       exp_w [2];
    exp_c = '{8'd255, 8'd4}; exp_a1 = '{8'd63, 8'd68}; exp_w = '{1'b0, 1'b1};
    mode = 2'd0; incr = 8'd5; load_val = 8'd250; load = 1;
    tick();
    load = 0;
    for (int n = 0; n < 2; n++) begin
      tick();
      tests++;
      if (addr[7:0] !== exp_c[n] || addr[15:8] !== exp_a1[n] || wrap !== exp_w[n] || dir !== 1'b0) begin
        fails++;
        $display("FAIL up_wrap[%0d]: cnt=%0d addr1=%0d wrap=%b dir=%b, required %0d %0d %b 0",
                 n, addr[7:0], addr[15:8], wrap, dir, exp_c[n], exp_a1[n], exp_w[n]);
      end
    end
  endtask

  task automatic test_down_borrow();
    mode = 2'd1; incr = 8'd4; load_val = 8'd3; load = 1;
    tick();
    load = 0;
    tick();
    tests++;
    if (addr[7:0] !== 8'd255 || wrap !== 1'b1 || dir !== 1'b1) begin
      fails++;
      $display("FAIL down_borrow: cnt=%0d wrap=%b dir=%b, required 255 1 1", addr[7:0], wrap, dir);
    end
    tick();
    tests++;
    if (addr[7:0] !== 8'd251 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL down_next: cnt=%0d wrap=%b, required 251 0", addr[7:0], wrap);
    end
  endtask

  task automatic test_ping();
    logic [7:0] exp_c [5];
    logic       exp_w [5];
    logic       exp_d [5];
    exp_c = '{8'd254, 8'd255, 8'd251, 8'd0, 8'd4};
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_d = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    mode = 2'd0; load_val = 8'd250; load = 1;   // load in UP to start the sweep upward
    tick();
    load = 0; mode = 2'd2; incr = 8'd4;
    for (int n = 0; n < 5; n++) begin
      if (n == 3) begin
        load_val = 8'd2; load = 1;
        tick();
        load = 0;
      end
      tick();
      tests++;
      if (addr[7:0] !== exp_c[n] || wrap !== exp_w[n] || dir !== exp_d[n]) begin
        fails++;
        $display("FAIL ping[%0d]: cnt=%0d wrap=%b dir=%b, required %0d %b %b",
                 n, addr[7:0], wrap, dir, exp_c[n], exp_w[n], exp_d[n]);
      end
    end
  endtask

  task automatic test_priority_hold();
    logic [15:0] a_hold;
    logic        d_hold;
    mode = 2'd0; en = 1; incr = 8'd3; load_val = 8'd9; load = 1;
    tick();
    load = 0;
    tests++;
    if (addr[7:0] !== 8'd9) begin
      fails++;
      $display("FAIL load_over_en: cnt=%0d, required 9", addr[7:0]);
    end
    mode = 2'd3;
    a_hold = {8'd73, 8'd9}; d_hold = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (n == 2) offset = {8'd10, 8'd0};   // must not show while holding
      tick();
      tests++;
      if (addr !== a_hold || dir !== d_hold || wrap !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d]: addr=%h dir=%b wrap=%b, required %h %b 0", n, addr, dir, wrap, a_hold, d_hold);
      end
    end
    mode = 2'd0;
    tick();
    tests++;
    if (addr[7:0] !== 8'd12 || addr[15:8] !== 8'd22) begin
      fails++;
      $display("FAIL offset_apply: addr0=%0d addr1=%0d, required 12 22", addr[7:0], addr[15:8]);
    end
    offset = {8'd64, 8'd0};
    rst = 1; load = 1; load_val = 8'd77;
    tick();
    rst = 0; load = 0;
    tests++;
    if (addr !== 16'h0 || dir !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL rst_over_load: addr=%h dir=%b wrap=%b, required 0000 0 0", addr, dir, wrap);
    end
  endtask

  task automatic test_incr_zero();
    mode = 2'd2; en = 1; incr = 8'd0; load_val = 8'd255; load = 1;
    tick();   // dir is 0 after reset, PING load keeps it
    load = 0;
    tick();
    tests++;
    if (addr[7:0] !== 8'd255 || wrap !== 1'b1 || dir !== 1'b1) begin
      fails++;
      $display("FAIL ping_zero_step: cnt=%0d wrap=%b dir=%b, required 255 1 1", addr[7:0], wrap, dir);
    end
    mode = 2'd0;
    tick();
    tests++;
    if (addr[7:0] !== 8'd255 || wrap !== 1'b0 || dir !== 1'b0) begin
      fails++;
      $display("FAIL up_zero_step: cnt=%0d wrap=%b dir=%b, required 255 0 0", addr[7:0], wrap, dir);
    end
  endtask

`ifdef ADDR_GEN_SYNC_EN
  task automatic test_sync();
    mode = 2'd0; en = 1; incr = 8'd1; load_val = 8'd100; load = 1;
    tick();
    load = 0; sync = 1;
    tick();
    tests++;
    if (addr[7:0] !== 8'd0 || addr[15:8] !== 8'd64 || dir !== 1'b0) begin
      fails++;
      $display("FAIL sync: addr0=%0d addr1=%0d dir=%b, required 0 64 0", addr[7:0], addr[15:8], dir);
    end
    load = 1; load_val = 8'd7;
    tick();
    sync = 0; load = 0;
    tests++;
    if (addr[7:0] !== 8'd0) begin
      fails++;
      $display("FAIL sync_over_load: cnt=%0d, required 0", addr[7:0]);
    end
  endtask
`endif

  task automatic test_random();
    int r;
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
`ifdef ADDR_GEN_SYNC_EN
      sync = ($urandom_range(0, 24) == 0);
`endif
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 3);
      incr = (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(1, 4)) : 8'($urandom);
      load_val = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(250, 255));
      if ($urandom_range(0, 19) == 0) offset = 16'($urandom);
      tick();
      tests++;
      if (addr[7:0] !== 8'(m_addr[0]) || addr[15:8] !== 8'(m_addr[1]) ||
          dir !== 1'(m_dir) || wrap !== 1'(m_wrap)) begin
        fails++;
        $display("FAIL random[%0d]: addr0=%0d addr1=%0d dir=%b wrap=%b, required %0d %0d %0d %0d",
                 n, addr[7:0], addr[15:8], dir, wrap, m_addr[0], m_addr[1], m_dir, m_wrap);
      end
    end
  endtask

  initial begin
    m_cnt = 0; m_dir = 0; m_wrap = 0;
    for (int k = 0; k < N; k++) m_addr[k] = 0;
    offset = '0;
    idle_inputs();
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_ping();
    test_priority_hold();
    test_incr_zero();
`ifdef ADDR_GEN_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/addr_gen.md
Name: addr_gen

Overview:
- Parametrised successor to the lab's basic enable/increment counter.
- Keeps a single base phase counter with programmable step and mode (up, down, ping-pong, hold), plus synchronous load.
- Drives NCH registered ROM address outputs, each offset from the base by a per-channel phase offset.
- Sits between control inputs (rotary/vbuddy values) and the waveform ROM(s) of the signal generator.

Parameters:
- WIDTH, 8, bit width of count, step, offsets and addresses.
- NCH, 2, number of address channels (NCH >= 1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  advance enable.
- mode  input  2  0=UP, 1=DOWN, 2=PING (ping-pong), 3=HOLD.
- incr  input  WIDTH  step size, unsigned.
- load  input  1  synchronous load of the base counter.
- load_val  input  WIDTH  value loaded when load=1.
- offset  input  NCH*WIDTH  per-channel phase offset; channel k uses bits [k*WIDTH +: WIDTH].
- addr  output  NCH*WIDTH  registered channel addresses; same packing as offset.
- dir  output  1  current direction: 0=up, 1=down.
- wrap  output  1  one-cycle pulse on wrap (UP/DOWN) or turn-around (PING).

Behaviour:
- Definitions: MAX = 2^WIDTH-1. cnt is the internal base register; cnt_n is its next value.
- Priority per edge, highest first: rst, [sync], load, HOLD, en, idle.
- rst=1: cnt=0, dir=0, wrap=0, all addr=0. This holds regardless of other inputs, including mid-sweep.
- load=1: cnt_n=load_val. dir is unchanged, except in UP/DOWN where dir takes the mode direction. wrap_n=0.
- mode=HOLD, or en=0: cnt held, dir held, wrap_n=0.
- UP, en=1:
  - cnt_n = (cnt+incr) mod 2^WIDTH; dir=0.
  - wrap_n=1 iff the WIDTH+1-bit sum carries out.
- DOWN, en=1:
  - cnt_n = (cnt-incr) mod 2^WIDTH; dir=1.
  - wrap_n=1 iff cnt < incr (borrow).
- PING, en=1, dir=0:
  - If cnt+incr >= MAX (computed in WIDTH+1 bits): cnt_n=MAX, dir_n=1, wrap_n=1.
  - Else cnt_n=cnt+incr.
- PING, en=1, dir=1:
  - If cnt <= incr: cnt_n=0, dir_n=0, wrap_n=1.
  - Else cnt_n=cnt-incr.
- incr=0 with en=1: cnt unchanged, wrap_n=0 in UP/DOWN. In PING a turn-around still fires when cnt is at the boundary (MAX up, 0 down).
- Mode change takes effect on the next edge.
  - Entering PING keeps the current dir.
  - Entering UP/DOWN forces dir to the mode direction on the first enabled or loaded edge.
- addr[k]_n = (cnt_n + offset[k]) mod 2^WIDTH, registered on the same edge as cnt.
  - addr is therefore aligned with the base value, with zero added latency.
  - An offset change appears on addr only at the next state update (en, load or sync edge). It is not re-added while holding.
- wrap is registered and high for exactly one cycle per event.

Optional Feature:
- Macro: ADDR_GEN_SYNC_EN.
- Defined:
  - Adds input port sync (1 bit).
  - sync=1 gives cnt_n=0, dir_n=0, wrap_n=0, addr[k]_n=offset[k]. This re-phases multiple instances.
  - Priority is below rst and above load.
- Undefined: no sync port and no extra logic; behaviour is as above.

Decomposition:
- Package addr_gen_pkg:
  - typedef enum logic [1:0] mode_t {MODE_UP, MODE_DOWN, MODE_PING, MODE_HOLD}.
  - Constants DIR_UP=0 and DIR_DOWN=1.
- Sub-module addr_gen_step: combinational next-state unit. Inputs cnt, dir, mode, incr. Outputs cnt_n, dir_n, wrap_n.
- Top: priority mux, registers, and a generate loop of NCH offset adders.

Test Plan:
- Reset: WIDTH=8, NCH=2, offset={64,0}, mode=UP, incr=1, en=1, then rst=1 for 2 cycles → addr0=0, addr1=0, dir=0, wrap=0. The first edge after release gives addr0=1, addr1=65.
- UP wrap: load_val=250, incr=5, 2 enabled edges → cnt 255, then 4. wrap=1 only on the edge producing 4. addr1 (offset 64) = 63, then 68.
- DOWN borrow: load_val=3, mode=DOWN, incr=4 → cnt=255, wrap=1, dir=1. The next edge gives 251 with wrap=0.
- PING turn-around: load_val=250, mode=PING, incr=4 → 254, then 255 (wrap=1, dir=1), then 251. Load 2 → 0 (wrap=1, dir=0), then 4.
- Priority and hold:
  - load=1 with en=1 and mode=UP, load_val=9 → cnt=9 with no increment.
  - mode=HOLD with en=1 → cnt, addr and dir constant for 5 cycles, wrap=0.
  - rst=1 with load=1 → 0.
- ADDR_GEN_SYNC_EN defined: mid-sweep cnt=100, sync=1 → addr0=0, addr1=64, dir=0. sync=1 together with load=1 (load_val=7) → cnt=0.
